// File: rtl/core_pkg.sv
// Shared definitions for the pipelined ARM core front end.
//   NOP_INSTR     : bubble encoding (MOV r0,r0) placed in Decode when empty
//   RESET_PC      : default fetch address after reset
//   fetch_state_e : fetch FSM states
//   word_align()  : forces bits [1:0] of a branch target to zero
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,  // no request outstanding
    FS_REQ  = 2'd1,  // request outstanding at the request address
    FS_HOLD = 2'd2,  // fetched word parked in the skid buffer
    FS_DROP = 2'd3   // outstanding request is stale; its data is thrown away
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding a fetched {instruction, pc+8} pair while
// Decode is stalled or being flushed.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture instr_i/pc8_i and mark the entry valid
//   unload_i      : entry consumed by Decode; mark it empty
//   clear_i       : discard the entry (redirect); wins over load_i
//   instr_i/pc8_i : word and pc+8 to capture
//   instr_o/pc8_o : stored word and pc+8
//   valid_o       : entry holds a word
module fetch_skid (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc8_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc8_o,
  output logic        valid_o
);
  import core_pkg::*;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;

  // Next-state for the skid entry: clear/unload empty it, load fills it.
  always_comb begin
    instr_d = instr_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    if (clear_i || unload_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc8_d   = pc8_i;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Skid entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= NOP_INSTR;
      pc8_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc8_o   = pc8_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, the instruction-memory handshake and the
// Fetch->Decode register. Redirects, pending PC writes, stalls and flushes
// are absorbed here so Decode only sees real instructions or NOP bubbles.
//   clk, reset             : clock, asynchronous active-low reset
//   StallD / FlushD        : Decode hold / load-bubble controls
//   PCWrPendingF           : PC write in flight; issue no new fetch
//   BranchTakenD/TargetD   : early branch redirect
//   PCSrcW / ResultW       : writeback redirect (higher priority)
//   ImemReq/ImemAddr       : registered request to instruction memory
//   ImemAck/ImemRData      : read data return (may come same cycle)
//   InstrD/PCPlus8D/ValidD : Decode register
//   PCF                    : next fetch address
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCWrPendingF,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic [31:0] PCF
);
  import core_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc8_q, pc8_d;
  logic         valid_q, valid_d;

  logic         redir_s;
  logic [31:0]  target_s;
  logic [31:0]  req_plus4_s;
  logic [31:0]  req_plus8_s;
  logic         start_fetch_s;
  logic [31:0]  start_addr_s;

  logic         skid_load_s;
  logic         skid_unload_s;
  logic         skid_clear_s;
  logic [31:0]  skid_instr_s;
  logic [31:0]  skid_pc8_s;
  logic         skid_valid_s;

  // Writeback redirect beats the early branch redirect.
  assign redir_s     = PCSrcW | BranchTakenD;
  assign target_s    = word_align(PCSrcW ? ResultW : BranchTargetD);
  assign req_plus4_s = req_addr_q + 32'd4;
  assign req_plus8_s = req_addr_q + 32'd8;

  fetch_skid u_skid (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (skid_load_s),
    .unload_i (skid_unload_s),
    .clear_i  (skid_clear_s),
    .instr_i  (ImemRData),
    .pc8_i    (req_plus8_s),
    .instr_o  (skid_instr_s),
    .pc8_o    (skid_pc8_s),
    .valid_o  (skid_valid_s)
  );

  // FSM next state, fetch PC, request address, Decode register and skid control.
  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    pc8_d         = pc8_q;
    valid_d       = valid_q;
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    skid_clear_s  = 1'b0;
    start_fetch_s = 1'b0;
    start_addr_s  = pcf_q;

    // Decode register default: a stall holds it; otherwise it gets a bubble
    // unless a word is delivered below. PCPlus8D is left alone for bubbles.
    if (redir_s || FlushD || !StallD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d = instr_q;
      valid_d = valid_q;
    end

    case (state_q)
      FS_IDLE: begin
        if (redir_s) begin
          pcf_d = target_s;
        end else if (PCWrPendingF) begin
          state_d = FS_IDLE;
        end else begin
          req_addr_d = pcf_q;
          state_d    = FS_REQ;
        end
      end

      FS_REQ: begin
        if (redir_s) begin
          pcf_d = target_s;
          if (ImemAck) begin
            start_fetch_s = 1'b1;
            start_addr_s  = target_s;
          end else begin
            state_d = FS_DROP;
          end
        end else if (ImemAck) begin
          pcf_d = req_plus4_s;
          // A flush owns the D register this edge, so the word is parked
          // and handed over the following cycle.
          if (StallD || FlushD) begin
            skid_load_s = 1'b1;
            state_d     = FS_HOLD;
          end else begin
            instr_d       = ImemRData;
            pc8_d         = req_plus8_s;
            valid_d       = 1'b1;
            start_fetch_s = 1'b1;
            start_addr_s  = req_plus4_s;
          end
        end else begin
          state_d = FS_REQ;
        end
      end

      FS_HOLD: begin
        if (redir_s) begin
          skid_clear_s  = 1'b1;
          pcf_d         = target_s;
          start_fetch_s = 1'b1;
          start_addr_s  = target_s;
        end else if (!StallD && !FlushD) begin
          instr_d       = skid_instr_s;
          pc8_d         = skid_pc8_s;
          valid_d       = skid_valid_s;
          skid_unload_s = 1'b1;
          start_fetch_s = 1'b1;
          start_addr_s  = pcf_q;
        end else begin
          state_d = FS_HOLD;
        end
      end

      FS_DROP: begin
        if (redir_s) begin
          pcf_d = target_s;
        end else begin
          pcf_d = pcf_q;
        end
        // The stale word is never used; once it lands, fetch the live PC.
        if (ImemAck) begin
          start_fetch_s = 1'b1;
          start_addr_s  = redir_s ? target_s : pcf_q;
        end else begin
          state_d = FS_DROP;
        end
      end

      default: begin
        state_d = FS_IDLE;
      end
    endcase

    // Common "begin fetching at start_addr_s" rule: issue unless a PC write
    // is pending, in which case park in IDLE with the address in PCF.
    if (start_fetch_s) begin
      pcf_d = start_addr_s;
      if (PCWrPendingF) begin
        state_d = FS_IDLE;
      end else begin
        state_d    = FS_REQ;
        req_addr_d = start_addr_s;
      end
    end else begin
      req_addr_d = req_addr_d;
    end
  end

  // State, PC, request address and Decode register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      pcf_q      <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc8_q      <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc8_q      <= pc8_d;
      valid_q    <= valid_d;
    end
  end

  // Request is a pure decode of the state register, so no input reaches it.
  assign ImemReq  = (state_q == FS_REQ) || (state_q == FS_DROP);
  assign ImemAddr = req_addr_q;
  assign InstrD   = instr_q;
  assign PCPlus8D = pc8_q;
  assign ValidD   = valid_q;
  assign PCF      = pcf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple memory responder that returns
// the request address as data after a programmable number of wait cycles.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        PCWrPendingF;
  logic        BranchTakenD;
  logic [31:0] BranchTargetD;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;
  logic [31:0] PCF;

  int n_cmp = 0;
  int n_err = 0;
  int wait_n = 0;
  int cnt;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .PCWrPendingF  (PCWrPendingF),
    .BranchTakenD  (BranchTakenD),
    .BranchTargetD (BranchTargetD),
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .ImemReq       (ImemReq),
    .ImemAddr      (ImemAddr),
    .ImemAck       (ImemAck),
    .ImemRData     (ImemRData),
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD),
    .PCF           (PCF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: counts cycles a request has been waiting.
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 0;
    else if (!ImemReq || ImemAck) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign ImemAck   = ImemReq && (cnt >= wait_n);
  assign ImemRData = ImemAddr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCWrPendingF = 1'b0;
    BranchTakenD = 1'b0; BranchTargetD = 32'h0; PCSrcW = 1'b0; ResultW = 32'h0;
    wait_n = 0;
    step(); step();
    chk("rst_req",   {31'd0, ImemReq}, 32'd0);
    chk("rst_addr",  ImemAddr, 32'h0);
    chk("rst_pcf",   PCF, 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_pc8",   PCPlus8D, 32'h0);

    // Zero-wait streaming.
    reset = 1'b1;
    step();
    chk("first_req",  {31'd0, ImemReq}, 32'd1);
    chk("first_addr", ImemAddr, 32'h0);
    chk("first_val",  {31'd0, ValidD}, 32'd0);
    step();
    chk("zw0_instr", InstrD, 32'h0);
    chk("zw0_pc8",   PCPlus8D, 32'h8);
    chk("zw0_valid", {31'd0, ValidD}, 32'd1);
    chk("zw0_addr",  ImemAddr, 32'h4);
    step();
    chk("zw1_instr", InstrD, 32'h4);
    chk("zw1_pc8",   PCPlus8D, 32'hC);
    step();
    chk("zw2_instr", InstrD, 32'h8);
    chk("zw2_pc8",   PCPlus8D, 32'h10);
    chk("zw2_addr",  ImemAddr, 32'hC);

    // Three-wait memory: one valid instruction every four cycles.
    wait_n = 3;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        chk("w3_bubble", {31'd0, ValidD}, 32'd0);
        chk("w3_addr",   ImemAddr, 32'hC + 32'(4 * i));
        chk("w3_req",    {31'd0, ImemReq}, 32'd1);
      end
      step();
      chk("w3_instr", InstrD, 32'hC + 32'(4 * i));
      chk("w3_valid", {31'd0, ValidD}, 32'd1);
      chk("w3_pc8",   PCPlus8D, 32'h14 + 32'(4 * i));
    end

    // Reset while a request is outstanding.
    reset = 1'b0;
    #1;
    chk("mid_rst_req",  {31'd0, ImemReq}, 32'd0);
    chk("mid_rst_addr", ImemAddr, 32'h0);
    chk("mid_rst_val",  {31'd0, ValidD}, 32'd0);
    step();
    wait_n = 0;
    reset = 1'b1;
    step();
    chk("rr_addr0", ImemAddr, 32'h0);
    step();
    step();
    chk("rr_instr4", InstrD, 32'h4);
    chk("rr_addr8",  ImemAddr, 32'h8);

    // Branch while the request at 0x8 is outstanding.
    wait_n = 3;
    step();
    chk("br_pre_bubble", {31'd0, ValidD}, 32'd0);
    BranchTakenD = 1'b1; BranchTargetD = 32'h0000_0103;
    step();
    BranchTakenD = 1'b0;
    chk("drop_pcf",  PCF, 32'h100);
    chk("drop_addr", ImemAddr, 32'h8);
    chk("drop_req",  {31'd0, ImemReq}, 32'd1);
    step();
    chk("drop_addr2", ImemAddr, 32'h8);
    chk("drop_val",   {31'd0, ValidD}, 32'd0);
    step();
    chk("drop_done_addr",  ImemAddr, 32'h100);
    chk("drop_done_val",   {31'd0, ValidD}, 32'd0);
    chk("drop_done_instr", InstrD, NOP);
    wait_n = 0;
    step();
    chk("br_instr", InstrD, 32'h100);
    chk("br_pc8",   PCPlus8D, 32'h108);
    chk("br_valid", {31'd0, ValidD}, 32'd1);

    // Writeback redirect beats branch redirect.
    PCSrcW = 1'b1; ResultW = 32'h200;
    BranchTakenD = 1'b1; BranchTargetD = 32'h100;
    step();
    PCSrcW = 1'b0; BranchTakenD = 1'b0;
    chk("prio_pcf",  PCF, 32'h200);
    chk("prio_addr", ImemAddr, 32'h200);
    chk("prio_val",  {31'd0, ValidD}, 32'd0);
    step();
    chk("prio_instr", InstrD, 32'h200);

    // Three-cycle stall with the ack in the first cycle.
    StallD = 1'b1;
    step();
    chk("st0_req",   {31'd0, ImemReq}, 32'd0);
    chk("st0_instr", InstrD, 32'h200);
    chk("st0_valid", {31'd0, ValidD}, 32'd1);
    chk("st0_pcf",   PCF, 32'h208);
    step();
    chk("st1_req", {31'd0, ImemReq}, 32'd0);
    step();
    chk("st2_req",   {31'd0, ImemReq}, 32'd0);
    chk("st2_instr", InstrD, 32'h200);
    StallD = 1'b0;
    step();
    chk("st_rel_instr", InstrD, 32'h204);
    chk("st_rel_pc8",   PCPlus8D, 32'h20C);
    chk("st_rel_addr",  ImemAddr, 32'h208);
    chk("st_rel_req",   {31'd0, ImemReq}, 32'd1);
    step();
    chk("st_next_instr", InstrD, 32'h208);

    // Pending PC write: no new requests, bubbles via FlushD, then resume.
    PCWrPendingF = 1'b1;
    step();
    chk("pw0_instr", InstrD, 32'h20C);
    chk("pw0_req",   {31'd0, ImemReq}, 32'd0);
    chk("pw0_pcf",   PCF, 32'h210);
    FlushD = 1'b1;
    step();
    chk("pw1_req",   {31'd0, ImemReq}, 32'd0);
    chk("pw1_val",   {31'd0, ValidD}, 32'd0);
    chk("pw1_instr", InstrD, NOP);
    chk("pw1_pc8",   PCPlus8D, 32'h214);
    step();
    chk("pw2_req", {31'd0, ImemReq}, 32'd0);
    PCWrPendingF = 1'b0; FlushD = 1'b0;
    step();
    chk("pw_res_req",  {31'd0, ImemReq}, 32'd1);
    chk("pw_res_addr", ImemAddr, 32'h210);
    chk("pw_res_val",  {31'd0, ValidD}, 32'd0);
    step();
    chk("pw_res_instr", InstrD, 32'h210);
    chk("pw_res_pc8",   PCPlus8D, 32'h218);

    // Flush in the same cycle as an ack: word parked, released next cycle.
    FlushD = 1'b1;
    step();
    FlushD = 1'b0;
    chk("fa_val", {31'd0, ValidD}, 32'd0);
    chk("fa_req", {31'd0, ImemReq}, 32'd0);
    chk("fa_pc8", PCPlus8D, 32'h218);
    chk("fa_pcf", PCF, 32'h218);
    step();
    chk("fa_rel_instr", InstrD, 32'h214);
    chk("fa_rel_val",   {31'd0, ValidD}, 32'd1);
    chk("fa_rel_pc8",   PCPlus8D, 32'h21C);
    chk("fa_rel_addr",  ImemAddr, 32'h218);

    // Wrap-around of +4/+8 with an unaligned target.
    PCSrcW = 1'b1; ResultW = 32'hFFFF_FFFF;
    step();
    PCSrcW = 1'b0;
    chk("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
    chk("wrap_pcf",  PCF, 32'hFFFF_FFFC);
    step();
    chk("wrap_instr", InstrD, 32'hFFFF_FFFC);
    chk("wrap_pc8",   PCPlus8D, 32'h0000_0004);
    chk("wrap_next",  ImemAddr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage of the pipelined ARM core. Owns the fetch PC and the handshake with instruction memory, and writes the Fetch→Decode register. That register supplies `InstrD` to the decode controller. The unit reacts to the controller's redirect and pending-PC-write indications: it suspends, redirects and discards fetches so Decode only ever sees valid instructions or NOP bubbles.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `NOP_INSTR`, default 32'hE1A0_0000: bubble encoding (MOV r0,r0).

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `StallD`  in  1  Decode holds its instruction; the D register must not change.
- `FlushD`  in  1  Decode register loads a bubble at the next edge.
- `PCWrPendingF`  in  1  a PC write is in flight in D/E/M; no new fetch is issued.
- `BranchTakenD`  in  1  early branch redirect.
- `BranchTargetD`  in  32  target for `BranchTakenD`.
- `PCSrcW`  in  1  writeback redirect (write to r15).
- `ResultW`  in  32  target for `PCSrcW`.
- `ImemReq`  out  1  request valid, held until `ImemAck`.
- `ImemAddr`  out  32  word address; stable while `ImemReq`.
- `ImemAck`  in  1  read data valid; may assert in the same cycle as `ImemReq`.
- `ImemRData`  in  32  instruction word.
- `InstrD`  out  32  Decode instruction.
- `PCPlus8D`  out  32  fetch address + 8 for the instruction in D.
- `ValidD`  out  1  `InstrD` is a real instruction, not a bubble.
- `PCF`  out  32  next fetch address.

## Operation
- Registers: `PCF`, `ReqAddr`, `InstrD`/`PCPlus8D`/`ValidD`, skid buffer (`SkidInstr`, `SkidPC`, `SkidValid`), FSM state.
- FSM states:
  - IDLE: no request.
  - REQ: request outstanding at `ReqAddr`.
  - HOLD: fetched word parked in the skid buffer, Decode stalled.
  - DROP: outstanding request is stale; its data will be discarded.
- Redirect: `PCSrcW` takes priority over `BranchTakenD`. On redirect, `PCF` ← target, the skid buffer is cleared, and the D register loads a bubble regardless of `StallD`.
- IDLE:
  - Redirect or `PCWrPendingF` → stay IDLE; `PCF` is updated on redirect.
  - Otherwise `ReqAddr` ← `PCF` → REQ.
- REQ:
  - `ImemAck` with no redirect and `StallD`=0: D ← {`ImemRData`, `ReqAddr`+8, valid}; `PCF` ← `ReqAddr`+4. Then REQ again at `ReqAddr`+4 if `PCWrPendingF`=0, else IDLE.
  - `ImemAck` with `StallD`=1: skid ← {data, `ReqAddr`+8}, `PCF` ← `ReqAddr`+4 → HOLD.
  - Redirect without ack → DROP. Redirect with ack → data discarded; REQ at the target unless `PCWrPendingF`, else IDLE.
- HOLD:
  - `ImemReq`=0.
  - When `StallD`=0: D ← skid; next state follows the REQ/IDLE rule above.
  - Redirect → skid discarded, same rule applied to the target.
- DROP:
  - `ImemReq` stays high at the old `ReqAddr`.
  - On `ImemAck`: data discarded → REQ at `PCF`, or IDLE if `PCWrPendingF`.
  - A further redirect updates `PCF` only.
- `FlushD` (no redirect): D ← bubble; the fetch in progress continues. If an ack arrives the same cycle, the word is kept (skid if `StallD`, otherwise dropped into D after the flush).
  - Rule: flush wins the D register. The acked word goes to skid → HOLD and is released the next cycle.
- `StallD`=1 and no flush/redirect: D unchanged.
- Bubble: `InstrD`=`NOP_INSTR`, `ValidD`=0, `PCPlus8D` unchanged.
- Arithmetic: 32-bit wrap-around on +4 and +8; bits [1:0] of targets are forced to 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `PCF`=`RESET_PC`, state IDLE, `ImemReq`=0, `ImemAddr`=`RESET_PC`.
  - `InstrD`=`NOP_INSTR`, `ValidD`=0, `PCPlus8D`=0, skid empty.
  - First `ImemReq` occurs one cycle after release.
- Reset mid-request: the request is abandoned; memory must tolerate `ImemReq` dropping.
- `ImemReq`/`ImemAddr` are registered (Moore); no combinational path from any input to them.
- Zero-wait memory (ack same cycle): one instruction per cycle; `InstrD` valid one edge after ack.
- N-wait memory: one instruction per N+1 cycles.
- Redirect to first target request: one cycle (IDLE/REQ), or after the stale ack (DROP).

## Structure
- Shared package `core_pkg`: `NOP_INSTR`, the FSM state enum (IDLE/REQ/HOLD/DROP), and the `RESET_PC` default.
- One sub-module, `fetch_skid`: a one-entry {instr, pc+8} skid register with load/unload/clear.
- The D register and FSM live in `fetch_unit`.

## Test plan
- Reset release, zero-wait memory returning address as data → `ImemAddr` 0,4,8,…; `InstrD` 0,4,8 on consecutive cycles; `PCPlus8D`=8,12,16.
- 3-wait memory → one `ValidD` instruction every 4 cycles; `ImemAddr` stable while `ImemReq`.
- `BranchTakenD` to 0x100 while the request at 0x8 is outstanding → DROP; 0x8 data never reaches D; next `ImemAddr`=0x100.
- `PCSrcW` (0x200) and `BranchTakenD` (0x100) in the same cycle → `PCF`=0x200.
- `StallD` for 3 cycles with ack in the first → skid holds the word; `ImemReq`=0 for those cycles; the word appears in D the cycle after `StallD` drops; no loss or duplication.
- `PCWrPendingF` held 3 cycles → no new `ImemReq`; D shows bubbles (with `FlushD`); fetch resumes at `PCF` afterwards.
